// File: rtl/apb_slave_pkg17.sv
// Shared types and register-map constants for the APB register-file responder.
package apb_slave_pkg17;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

  localparam int CTRL_OFF     = 'h0;
  localparam int STATUS_OFF   = 'h4;
  localparam int INT_STAT_OFF = 'h8;
  localparam int INT_MASK_OFF = 'hC;

  localparam int STATUS_ERR_BIT = 8;
  localparam int CTRL_CLR_BIT   = 31;

endpackage

// File: rtl/apb_slave_irq17.sv
// Interrupt status (W1C, event set wins), interrupt mask and registered irq.
module apb_slave_irq17 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] evt_i,
  input  logic       stat_w1c_i,
  input  logic       mask_we_i,
  input  logic [7:0] wdata_i,
  output logic [7:0] int_stat_o,
  output logic [7:0] int_mask_o,
  output logic       irq_o
);

  logic [7:0] stat_q, stat_d;
  logic [7:0] mask_q, mask_d;
  logic       irq_q;

  always_comb begin
    stat_d = stat_q;
    if (stat_w1c_i) stat_d = stat_q & ~wdata_i;
    // Applied after the clear so a same-cycle event keeps its bit set.
    stat_d = stat_d | evt_i;
    mask_d = mask_we_i ? wdata_i : mask_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_q <= '0;
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      stat_q <= stat_d;
      mask_q <= mask_d;
      irq_q  <= |(stat_q & mask_q);
    end
  end

  assign int_stat_o = stat_q;
  assign int_mask_o = mask_q;
  assign irq_o      = irq_q;

endmodule

// File: rtl/apb_slave_regfile17.sv
// APB3 completer serving a small register file with wait states, pslverr and irq.
// Handshake: a transfer starts on psel&!penable; pready pulses one cycle, and the
// write lands at the edge ending that cycle only if psel&penable are still high.
module apb_slave_regfile17
  import apb_slave_pkg17::*;
#(
  parameter int          PADDR_WIDTH17 = 32,
  parameter int          PDATA_WIDTH17 = 32,
  parameter int          NUM_REGS17    = 8,
  parameter logic [31:0] BASE_ADDR17   = 32'h0,
  parameter int          WAIT_STATES17 = 0
) (
  input  logic                     pclock17,
  input  logic                     preset17,
  input  logic                     psel17,
  input  logic                     penable17,
  input  logic                     prwd17,
  input  logic [PADDR_WIDTH17-1:0] paddr17,
  input  logic [31:0]              pwdata17,
  output logic [31:0]              prdata17,
  output logic                     pready17,
  output logic                     pslverr17,
  input  logic [7:0]               evt17,
  output logic                     irq17,
  output apb_state_e               state_o
);

  localparam int IW = (NUM_REGS17 > 1) ? $clog2(NUM_REGS17) : 1;
  localparam logic [PADDR_WIDTH17-1:0] BASE = PADDR_WIDTH17'(BASE_ADDR17);

  apb_state_e               state_q;
  logic [PADDR_WIDTH17-1:0] addr_q;
  logic                     write_q;
  logic [31:0]              wdata_q;
  logic [3:0]               cnt_q;
  logic                     pready_q, pslverr_q, err_flag_q;
  logic [31:0]              prdata_q;
  logic [31:0]              regs_q [NUM_REGS17];

  logic [PADDR_WIDTH17-1:0] eff_addr, offset;
  logic                     eff_write, in_range, dec_err;
  logic [IW-1:0]            idx;
  logic [31:0]              rd_word;
  logic                     commit, wr_ok, ctrl_we, stat_w1c, mask_we, reg_we;
  logic [7:0]               int_stat, int_mask;

  // In IDLE the decode looks at the live bus so a zero-wait read can respond at once.
  always_comb begin
    eff_addr  = (state_q == IDLE) ? paddr17 : addr_q;
    eff_write = (state_q == IDLE) ? prwd17  : write_q;
    offset    = eff_addr - BASE;
    idx       = offset[IW+1:2];
    in_range  = (eff_addr >= BASE) && (offset < PADDR_WIDTH17'(NUM_REGS17 * 4));
    dec_err   = (eff_addr[1:0] != 2'b00) || !in_range ||
                (eff_write && offset == PADDR_WIDTH17'(STATUS_OFF));
    rd_word   = '0;
    if (!dec_err) begin
      if (offset == PADDR_WIDTH17'(STATUS_OFF))
        rd_word = {23'b0, err_flag_q, int_stat & int_mask};
      else if (offset == PADDR_WIDTH17'(INT_STAT_OFF))
        rd_word = {24'b0, int_stat};
      else if (offset == PADDR_WIDTH17'(INT_MASK_OFF))
        rd_word = {24'b0, int_mask};
      else
        rd_word = regs_q[idx];
    end
  end

  assign commit   = (state_q == ACCESS) && pready_q && psel17 && penable17;
  assign wr_ok    = commit && write_q && !dec_err;
  assign ctrl_we  = wr_ok && (offset == PADDR_WIDTH17'(CTRL_OFF));
  assign stat_w1c = wr_ok && (offset == PADDR_WIDTH17'(INT_STAT_OFF));
  assign mask_we  = wr_ok && (offset == PADDR_WIDTH17'(INT_MASK_OFF));
  assign reg_we   = wr_ok && !stat_w1c && !mask_we;

  always_ff @(posedge pclock17 or negedge preset17) begin
    if (!preset17) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (psel17 && !penable17) begin
            addr_q  <= paddr17;
            write_q <= prwd17;
            wdata_q <= pwdata17;
            cnt_q   <= 4'(WAIT_STATES17);
            state_q <= ACCESS;
            if (WAIT_STATES17 == 0) begin
              pready_q  <= 1'b1;
              pslverr_q <= dec_err;
              prdata_q  <= prwd17 ? 32'h0 : rd_word;
            end
          end
        end
        ACCESS: begin
          if (!psel17 || !penable17 || pready_q) begin
            state_q   <= IDLE;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
              pready_q  <= 1'b1;
              pslverr_q <= dec_err;
              prdata_q  <= write_q ? 32'h0 : rd_word;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge pclock17 or negedge preset17) begin
    if (!preset17) begin
      err_flag_q <= 1'b0;
      for (int i = 0; i < NUM_REGS17; i++) regs_q[i] <= '0;
    end else begin
      if (reg_we) regs_q[idx] <= wdata_q;
      if (commit && dec_err)
        err_flag_q <= 1'b1;
      else if (ctrl_we && wdata_q[CTRL_CLR_BIT])
        err_flag_q <= 1'b0;
    end
  end

  apb_slave_irq17 u_irq (
    .clk_i      (pclock17),
    .rst_ni     (preset17),
    .evt_i      (evt17),
    .stat_w1c_i (stat_w1c),
    .mask_we_i  (mask_we),
    .wdata_i    (wdata_q[7:0]),
    .int_stat_o (int_stat),
    .int_mask_o (int_mask),
    .irq_o      (irq17)
  );

  assign prdata17  = prdata_q;
  assign pready17  = pready_q;
  assign pslverr17 = pslverr_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_apb_slave_regfile17.sv
// Directed bench: two responders (0 and 3 wait states) on one APB bus, separate selects.
module tb_apb_slave_regfile17;
  import apb_slave_pkg17::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        psel0 = 1'b0, psel3 = 1'b0, penable = 1'b0, prwd = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0;
  logic [7:0]  evt0 = '0, evt_none = '0;
  logic [31:0] prdata0, prdata3;
  logic        pready0, pready3, pslverr0, pslverr3, irq0, irq3;
  apb_state_e  st0, st3;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  apb_slave_regfile17 #(.WAIT_STATES17(0)) dut0 (
    .pclock17(clk), .preset17(rst_n), .psel17(psel0), .penable17(penable),
    .prwd17(prwd), .paddr17(paddr), .pwdata17(pwdata), .prdata17(prdata0),
    .pready17(pready0), .pslverr17(pslverr0), .evt17(evt0), .irq17(irq0),
    .state_o(st0)
  );

  apb_slave_regfile17 #(.WAIT_STATES17(3)) dut3 (
    .pclock17(clk), .preset17(rst_n), .psel17(psel3), .penable17(penable),
    .prwd17(prwd), .paddr17(paddr), .pwdata17(pwdata), .prdata17(prdata3),
    .pready17(pready3), .pslverr17(pslverr3), .evt17(evt_none), .irq17(irq3),
    .state_o(st3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic rdy(input int sel);
    return (sel == 0) ? pready0 : pready3;
  endfunction

  // driver tasks: all bus changes happen on the falling edge
  task automatic setup(input int sel, input logic wr, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    psel0 = (sel == 0); psel3 = (sel != 0);
    penable = 1'b0; prwd = wr; paddr = a; pwdata = d;
  endtask

  task automatic xfer(input int sel, input logic wr, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic err, output int lat);
    setup(sel, wr, a, d);
    @(negedge clk);
    penable = 1'b1;
    lat = 1;
    while (!rdy(sel) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rd  = (sel == 0) ? prdata0 : prdata3;
    err = (sel == 0) ? pslverr0 : pslverr3;
  endtask

  task automatic bus_idle();
    @(negedge clk);
    psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0; prwd = 1'b0;
  endtask

  task automatic wr_chk(input int sel, input logic [31:0] a, input logic [31:0] d,
                        input logic exp_err, input int exp_lat, input string tag);
    logic [31:0] rd; logic err; int lat;
    xfer(sel, 1'b1, a, d, rd, err, lat);
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic rd_chk(input int sel, input logic [31:0] a, input logic [31:0] exp,
                        input logic exp_err, input int exp_lat, input string tag);
    logic [31:0] rd; logic err; int lat;
    exp_q.push_back(exp);
    xfer(sel, 1'b0, a, 32'h0, rd, err, lat);
    check({tag, "_data"}, rd, exp_q.pop_front());
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    // reset state
    repeat (3) @(negedge clk);
    check("rst_pready", 32'(pready0), 32'd0);
    check("rst_pslverr", 32'(pslverr0), 32'd0);
    check("rst_prdata", prdata0, 32'h0);
    check("rst_irq", 32'(irq0), 32'd0);
    check("rst_state", 32'(st0), 32'(IDLE));
    rst_n = 1'b1;

    // every register reads 0 after reset, zero-wait timing
    for (int i = 0; i < 8; i++) rd_chk(0, 32'(i * 4), 32'h0, 1'b0, 1, $sformatf("rst_rd%0d", i));

    // three wait states
    wr_chk(3, 32'h10, 32'hA5A5_0F0F, 1'b0, 4, "ws3_wr10");
    rd_chk(3, 32'h10, 32'hA5A5_0F0F, 1'b0, 4, "ws3_rd10");

    // error responses and sticky flag
    rd_chk(0, 32'h20, 32'h0, 1'b1, 1, "oor_rd20");
    wr_chk(0, 32'h4, 32'hFFFF_FFFF, 1'b1, 1, "wr_status");
    rd_chk(0, 32'h4, 32'h0000_0100, 1'b0, 1, "status_err");
    rd_chk(0, 32'h2, 32'h0, 1'b1, 1, "misalign");
    wr_chk(0, 32'h0, 32'h8000_0000, 1'b0, 1, "ctrl_clr");
    rd_chk(0, 32'h4, 32'h0, 1'b0, 1, "status_clr");
    rd_chk(0, 32'h0, 32'h8000_0000, 1'b0, 1, "ctrl_rd");
    bus_idle();
    check("idle_prdata", prdata0, 32'h0);

    // interrupt path
    wr_chk(0, 32'hC, 32'h1, 1'b0, 1, "mask_wr");
    bus_idle();
    @(negedge clk); evt0 = 8'h01;
    @(negedge clk); evt0 = 8'h00;
    check("irq_edge1", 32'(irq0), 32'd0);
    @(negedge clk);
    check("irq_edge2", 32'(irq0), 32'd1);
    rd_chk(0, 32'h8, 32'h1, 1'b0, 1, "int_stat_set");
    rd_chk(0, 32'h4, 32'h1, 1'b0, 1, "status_masked");
    wr_chk(0, 32'h8, 32'h1, 1'b0, 1, "w1c");
    bus_idle();
    @(negedge clk);
    check("irq_cleared", 32'(irq0), 32'd0);
    rd_chk(0, 32'h8, 32'h0, 1'b0, 1, "int_stat_clr");
    wr_chk(0, 32'h8, 32'h1, 1'b0, 1, "w1c_race");
    evt0 = 8'h01;
    @(negedge clk);
    evt0 = 8'h00; psel0 = 1'b0; penable = 1'b0;
    @(negedge clk);
    check("irq_race", 32'(irq0), 32'd1);
    rd_chk(0, 32'h8, 32'h1, 1'b0, 1, "set_wins");

    // penable dropped mid-access
    setup(3, 1'b1, 32'h14, 32'hDEAD_BEEF);
    @(negedge clk); penable = 1'b1;
    check("pv_rdy_a", 32'(pready3), 32'd0);
    @(negedge clk); penable = 1'b0;
    check("pv_rdy_b", 32'(pready3), 32'd0);
    @(negedge clk); psel3 = 1'b0;
    check("pv_rdy_c", 32'(pready3), 32'd0);
    check("pv_state", 32'(st3), 32'(IDLE));
    rd_chk(3, 32'h14, 32'h0, 1'b0, 4, "pv_rd14");

    // reset during the ready cycle
    setup(3, 1'b1, 32'h18, 32'h1234_5678);
    @(negedge clk); penable = 1'b1;
    lat = 1;
    while (!pready3 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("mr_pre_rdy", 32'(pready3), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mr_rdy", 32'(pready3), 32'd0);
    check("mr_state", 32'(st3), 32'(IDLE));
    check("mr_irq0", 32'(irq0), 32'd0);
    psel3 = 1'b0; penable = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    rd_chk(3, 32'h18, 32'h0, 1'b0, 4, "mr_rd18");
    rd_chk(3, 32'h10, 32'h0, 1'b0, 4, "mr_rd10");
    wr_chk(3, 32'h1C, 32'h0BAD_F00D, 1'b0, 4, "mr_wr1c");
    rd_chk(3, 32'h1C, 32'h0BAD_F00D, 1'b0, 4, "mr_rd1c");
    bus_idle();

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
